// File: rtl/pv2dualfetch_fetch_pair.sv
// Dual-port PARCv2 fetch: issues word reads at pc and pc+4 on two memory ports,
// pairs the in-order responses and hands each pair to decode as one packet.

module pv2dualfetch_fifo #(
    parameter int W = 32,
    parameter int D = 2
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   flush,
    input  logic                   push,
    input  logic [W-1:0]           din,
    input  logic                   pop,
    output logic [W-1:0]           dout,
    output logic [$clog2(D+1)-1:0] count
);
    localparam int PW = (D > 1) ? $clog2(D) : 1;
    localparam int CW = $clog2(D + 1);

    logic [W-1:0]  mem_q [D];
    logic [W-1:0]  mem_d [D];
    logic [PW-1:0] rd_q, rd_d, wr_q, wr_d;
    logic [CW-1:0] cnt_q, cnt_d;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(D - 1)) ? '0 : p + PW'(1);
    endfunction

    always_comb begin
        mem_d = mem_q;
        rd_d  = rd_q;
        wr_d  = wr_q;
        cnt_d = cnt_q;
        if (flush) begin
            rd_d  = '0;
            wr_d  = '0;
            cnt_d = '0;
        end else begin
            if (push) begin
                mem_d[wr_q] = din;
                wr_d        = ptr_inc(wr_q);
            end
            if (pop) rd_d = ptr_inc(rd_q);
            cnt_d = cnt_q + CW'(push) - CW'(pop);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            mem_q <= '{default: '0};
            rd_q  <= '0;
            wr_q  <= '0;
            cnt_q <= '0;
        end else begin
            mem_q <= mem_d;
            rd_q  <= rd_d;
            wr_q  <= wr_d;
            cnt_q <= cnt_d;
        end
    end

    assign dout  = mem_q[rd_q];
    assign count = cnt_q;
endmodule

module pv2dualfetch_fetch_pair #(
    parameter logic [31:0] p_reset_pc = 32'h0008_0000,
    parameter int          p_depth    = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        redirect_val,
    input  logic [31:0] redirect_pc,
    output logic [66:0] imemreq0_msg,
    output logic        imemreq0_val,
    input  logic        imemreq0_rdy,
    input  logic [34:0] imemresp0_msg,
    input  logic        imemresp0_val,
    output logic [66:0] imemreq1_msg,
    output logic        imemreq1_val,
    input  logic        imemreq1_rdy,
    input  logic [34:0] imemresp1_msg,
    input  logic        imemresp1_val,
    output logic        inst_val,
    input  logic        inst_rdy,
    output logic [31:0] inst_pc,
    output logic [31:0] inst0,
    output logic [31:0] inst1
);
    localparam int CW = $clog2(p_depth + 1);

    logic [31:0]   fetch_pc_q, fetch_pc_d;
    logic          sent0_q, sent0_d, sent1_q, sent1_d;
    logic [CW-1:0] inflight0_q, inflight0_d, inflight1_q, inflight1_d;
    logic [CW-1:0] drop0_q, drop0_d, drop1_q, drop1_d;
    logic [CW-1:0] cnt0, cnt1, pc_cnt;
    logic          fire0, fire1, both_done, pop, keep0, keep1;
    logic          unused_resp;

    // A transfer happens on any edge where val && rdy; val never waits on rdy.
    assign imemreq0_val = reset && !sent0_q &&
        (({1'b0, inflight0_q} + {1'b0, cnt0}) < (CW + 1)'(p_depth));
    assign imemreq1_val = reset && !sent1_q &&
        (({1'b0, inflight1_q} + {1'b0, cnt1}) < (CW + 1)'(p_depth));
    assign imemreq0_msg = {1'b0, fetch_pc_q, 2'b00, 32'h0};
    assign imemreq1_msg = {1'b0, fetch_pc_q + 32'd4, 2'b00, 32'h0};

    assign fire0     = imemreq0_val && imemreq0_rdy;
    assign fire1     = imemreq1_val && imemreq1_rdy;
    assign both_done = (sent0_q || fire0) && (sent1_q || fire1);
    assign keep0     = imemresp0_val && (drop0_q == '0) && !redirect_val;
    assign keep1     = imemresp1_val && (drop1_q == '0) && !redirect_val;
    assign pop       = inst_val && inst_rdy;
    assign unused_resp = ^{imemresp0_msg[34:32], imemresp1_msg[34:32]};

    always_comb begin
        fetch_pc_d  = fetch_pc_q;
        sent0_d     = sent0_q || fire0;
        sent1_d     = sent1_q || fire1;
        inflight0_d = inflight0_q + CW'(fire0) - CW'(imemresp0_val);
        inflight1_d = inflight1_q + CW'(fire1) - CW'(imemresp1_val);
        drop0_d     = drop0_q;
        drop1_d     = drop1_q;
        if (imemresp0_val && drop0_q != '0) drop0_d = drop0_q - CW'(1);
        if (imemresp1_val && drop1_q != '0) drop1_d = drop1_q - CW'(1);
        // Everything still in flight after a redirect edge belongs to the old path.
        if (redirect_val) begin
            fetch_pc_d = redirect_pc;
            sent0_d    = 1'b0;
            sent1_d    = 1'b0;
            drop0_d    = inflight0_d;
            drop1_d    = inflight1_d;
        end else if (both_done) begin
            fetch_pc_d = fetch_pc_q + 32'd8;
            sent0_d    = 1'b0;
            sent1_d    = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            fetch_pc_q  <= p_reset_pc;
            sent0_q     <= 1'b0;
            sent1_q     <= 1'b0;
            inflight0_q <= '0;
            inflight1_q <= '0;
            drop0_q     <= '0;
            drop1_q     <= '0;
        end else begin
            fetch_pc_q  <= fetch_pc_d;
            sent0_q     <= sent0_d;
            sent1_q     <= sent1_d;
            inflight0_q <= inflight0_d;
            inflight1_q <= inflight1_d;
            drop0_q     <= drop0_d;
            drop1_q     <= drop1_d;
        end
    end

    pv2dualfetch_fifo #(.W(32), .D(p_depth)) u_fifo0 (
        .clk(clk), .reset(reset), .flush(redirect_val), .push(keep0),
        .din(imemresp0_msg[31:0]), .pop(pop), .dout(inst0), .count(cnt0)
    );
    pv2dualfetch_fifo #(.W(32), .D(p_depth)) u_fifo1 (
        .clk(clk), .reset(reset), .flush(redirect_val), .push(keep1),
        .din(imemresp1_msg[31:0]), .pop(pop), .dout(inst1), .count(cnt1)
    );
    pv2dualfetch_fifo #(.W(32), .D(p_depth)) u_fifo_pc (
        .clk(clk), .reset(reset), .flush(redirect_val),
        .push(both_done && !redirect_val), .din(fetch_pc_q), .pop(pop),
        .dout(inst_pc), .count(pc_cnt)
    );

    assign inst_val = (pc_cnt != '0) && (cnt0 != '0) && (cnt1 != '0) && !redirect_val;
endmodule

// File: tb/tb_pv2dualfetch_fetch_pair.sv
// Bench for pv2dualfetch_fetch_pair: delayed in-order memory model on both ports,
// scoreboard of expected packets from a sequential PC stream, directed + random phases.

module tb_pv2dualfetch_fetch_pair;
    localparam logic [31:0] P_RESET_PC = 32'h0008_0000;

    logic        clk;
    logic        reset;
    logic        redirect_val;
    logic [31:0] redirect_pc;
    logic [66:0] req_msg0, req_msg1;
    logic        req_val0, req_val1, req_rdy0, req_rdy1;
    logic [34:0] resp_msg0, resp_msg1;
    logic        resp_val0, resp_val1;
    logic        inst_val, inst_rdy;
    logic [31:0] inst_pc, inst0, inst1;

    int          checks, failures, pkt_cnt, acc0, acc1, min_delay, max_delay;
    int unsigned cyc;
    logic [63:0] mq0[$];
    logic [63:0] mq1[$];
    logic [31:0] last0, last1;
    logic [95:0] exp_q[$];
    logic [31:0] next_pc;

    pv2dualfetch_fetch_pair dut (
        .clk(clk), .reset(reset),
        .redirect_val(redirect_val), .redirect_pc(redirect_pc),
        .imemreq0_msg(req_msg0), .imemreq0_val(req_val0), .imemreq0_rdy(req_rdy0),
        .imemresp0_msg(resp_msg0), .imemresp0_val(resp_val0),
        .imemreq1_msg(req_msg1), .imemreq1_val(req_val1), .imemreq1_rdy(req_rdy1),
        .imemresp1_msg(resp_msg1), .imemresp1_val(resp_val1),
        .inst_val(inst_val), .inst_rdy(inst_rdy),
        .inst_pc(inst_pc), .inst0(inst0), .inst1(inst1)
    );

    // ---------------- clock ----------------
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        cyc = 0;
        forever begin
            @(posedge clk);
            cyc++;
        end
    end

    // ---------------- helpers ----------------
    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ {a[15:0], a[31:16]} ^ 32'h5A5A_1234;
    endfunction

    function automatic logic [31:0] next_due(input logic [31:0] last);
        logic [31:0] due;
        due = cyc + 32'd1 + 32'($urandom_range(min_delay, max_delay));
        if (due <= last) due = last + 32'd1;
        return due;
    endfunction

    task automatic sb_refill();
        while (exp_q.size() < 4) begin
            exp_q.push_back({next_pc, mem_word(next_pc), mem_word(next_pc + 32'd4)});
            next_pc = next_pc + 32'd8;
        end
    endtask

    task automatic sb_restart(input logic [31:0] pc);
        exp_q.delete();
        next_pc = pc;
        sb_refill();
    endtask

    // ---------------- memory model (in order per port, variable delay) ----------------
    initial begin
        resp_val0 = 1'b0;
        resp_val1 = 1'b0;
        resp_msg0 = '0;
        resp_msg1 = '0;
        last0 = '0;
        last1 = '0;
        forever begin
            @(negedge clk);
            if (!reset) begin
                mq0.delete();
                mq1.delete();
                last0 = '0;
                last1 = '0;
                resp_val0 = 1'b0;
                resp_val1 = 1'b0;
            end else begin
                if (mq0.size() > 0 && mq0[0][63:32] <= cyc) begin
                    resp_val0 = 1'b1;
                    resp_msg0 = {3'b000, mq0[0][31:0]};
                    void'(mq0.pop_front());
                end else begin
                    resp_val0 = 1'b0;
                    resp_msg0 = {3'b000, $urandom()};
                end
                if (mq1.size() > 0 && mq1[0][63:32] <= cyc) begin
                    resp_val1 = 1'b1;
                    resp_msg1 = {3'b000, mq1[0][31:0]};
                    void'(mq1.pop_front());
                end else begin
                    resp_val1 = 1'b0;
                    resp_msg1 = {3'b000, $urandom()};
                end
            end
            #1;
            if (reset && req_val0 && req_rdy0) begin
                last0 = next_due(last0);
                mq0.push_back({last0, mem_word(req_msg0[65:34])});
                acc0++;
            end
            if (reset && req_val1 && req_rdy1) begin
                last1 = next_due(last1);
                mq1.push_back({last1, mem_word(req_msg1[65:34])});
                acc1++;
            end
        end
    end

    // ---------------- monitor / scoreboard ----------------
    initial begin
        logic [95:0] e;
        logic        hold_pend;
        logic [31:0] hold_pc, hold_i0, hold_i1;
        hold_pend = 1'b0;
        hold_pc = '0;
        hold_i0 = '0;
        hold_i1 = '0;
        forever begin
            @(negedge clk);
            #1;
            if (hold_pend && inst_val) begin
                chk("hold_pc", inst_pc, hold_pc);
                chk("hold_inst0", inst0, hold_i0);
                chk("hold_inst1", inst1, hold_i1);
            end
            hold_pend = inst_val && !inst_rdy;
            hold_pc = inst_pc;
            hold_i0 = inst0;
            hold_i1 = inst1;
            if (inst_val && inst_rdy) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL pkt_unexpected: got pc %h expected no packet", inst_pc);
                end else begin
                    e = exp_q.pop_front();
                    chk("pkt_pc", inst_pc, e[95:64]);
                    chk("pkt_inst0", inst0, e[63:32]);
                    chk("pkt_inst1", inst1, e[31:0]);
                end
                pkt_cnt++;
                sb_refill();
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic do_reset();
        @(negedge clk);
        reset = 1'b0;
        redirect_val = 1'b0;
        inst_rdy = 1'b0;
        req_rdy0 = 1'b0;
        req_rdy1 = 1'b0;
        min_delay = 0;
        max_delay = 0;
        acc0 = 0;
        acc1 = 0;
        sb_restart(P_RESET_PC);
        repeat (2) @(negedge clk);
        #2;
        chk("rst_req0_val", {31'b0, req_val0}, 32'd0);
        chk("rst_req1_val", {31'b0, req_val1}, 32'd0);
        chk("rst_inst_val", {31'b0, inst_val}, 32'd0);
    endtask

    task automatic release_reset(input logic rdy0, input logic rdy1, input logic irdy);
        @(negedge clk);
        reset = 1'b1;
        req_rdy0 = rdy0;
        req_rdy1 = rdy1;
        inst_rdy = irdy;
    endtask

    task automatic wait_inst(input string name, input int max_cyc);
        bit found;
        found = 1'b0;
        for (int i = 0; i < max_cyc && !found; i++) begin
            @(negedge clk);
            #2;
            if (inst_val) found = 1'b1;
        end
        if (!found) begin
            checks++;
            failures++;
            $display("FAIL %s: inst_val still 0 after %0d cycles, required 1", name, max_cyc);
        end
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int          start;
        logic [31:0] rpc;
        checks = 0;
        failures = 0;
        pkt_cnt = 0;
        acc0 = 0;
        acc1 = 0;
        min_delay = 0;
        max_delay = 0;
        redirect_val = 1'b0;
        redirect_pc = '0;
        inst_rdy = 1'b0;
        req_rdy0 = 1'b0;
        req_rdy1 = 1'b0;
        sb_restart(P_RESET_PC);
        reset = 1'b1;
        #3 reset = 1'b0;
        do_reset();

        // Reset release and first-packet latency, zero-delay memory.
        release_reset(1'b1, 1'b1, 1'b1);
        #2;
        chk("a_req0_val", {31'b0, req_val0}, 32'd1);
        chk("a_req1_val", {31'b0, req_val1}, 32'd1);
        chk("a_req0_addr", req_msg0[65:34], 32'h0008_0000);
        chk("a_req1_addr", req_msg1[65:34], 32'h0008_0004);
        chk("a_req0_ctl", {29'b0, req_msg0[66], req_msg0[33:32]}, 32'd0);
        chk("a_req1_data", req_msg1[31:0], 32'd0);
        @(negedge clk);
        #2;
        chk("a_req0_addr2", req_msg0[65:34], 32'h0008_0008);
        chk("a_req1_addr2", req_msg1[65:34], 32'h0008_000C);
        chk("a_inst_val_n1", {31'b0, inst_val}, 32'd0);
        @(negedge clk);
        #2;
        chk("a_inst_val_n2", {31'b0, inst_val}, 32'd1);
        chk("a_inst_pc", inst_pc, 32'h0008_0000);
        repeat (10) @(negedge clk);

        // Backpressure: credits run out after two packets per port.
        do_reset();
        release_reset(1'b1, 1'b1, 1'b0);
        repeat (5) @(negedge clk);
        #2;
        chk("b_acc0", 32'(acc0), 32'd2);
        chk("b_acc1", 32'(acc1), 32'd2);
        chk("b_req0_val", {31'b0, req_val0}, 32'd0);
        chk("b_req1_val", {31'b0, req_val1}, 32'd0);
        chk("b_inst_val", {31'b0, inst_val}, 32'd1);
        @(negedge clk);
        inst_rdy = 1'b1;
        #2;
        chk("b_pop_pc", inst_pc, 32'h0008_0000);
        @(negedge clk);
        inst_rdy = 1'b0;
        #2;
        chk("b_resume_val", {31'b0, req_val0}, 32'd1);
        chk("b_resume_addr0", req_msg0[65:34], 32'h0008_0010);
        chk("b_resume_addr1", req_msg1[65:34], 32'h0008_0014);
        @(negedge clk);
        inst_rdy = 1'b1;
        repeat (10) @(negedge clk);

        // Port skew: port 1 stalled for three cycles.
        do_reset();
        release_reset(1'b1, 1'b0, 1'b1);
        repeat (2) @(negedge clk);
        #2;
        chk("c_acc0", 32'(acc0), 32'd1);
        chk("c_acc1", 32'(acc1), 32'd0);
        chk("c_req0_hold", {31'b0, req_val0}, 32'd0);
        chk("c_inst_val", {31'b0, inst_val}, 32'd0);
        @(negedge clk);
        req_rdy1 = 1'b1;
        #2;
        chk("c_req1_val", {31'b0, req_val1}, 32'd1);
        chk("c_req1_addr", req_msg1[65:34], 32'h0008_0004);
        chk("c_req0_idle", {31'b0, req_val0}, 32'd0);
        @(negedge clk);
        #2;
        chk("c_req0_val", {31'b0, req_val0}, 32'd1);
        chk("c_req0_addr", req_msg0[65:34], 32'h0008_0008);
        repeat (10) @(negedge clk);

        // Redirect with two responses outstanding per port.
        do_reset();
        min_delay = 4;
        max_delay = 4;
        release_reset(1'b1, 1'b1, 1'b1);
        repeat (2) @(negedge clk);
        redirect_val = 1'b1;
        redirect_pc = 32'h0008_0100;
        sb_restart(32'h0008_0100);
        #2;
        chk("d_acc0", 32'(acc0), 32'd2);
        chk("d_acc1", 32'(acc1), 32'd2);
        chk("d_inst_val", {31'b0, inst_val}, 32'd0);
        @(negedge clk);
        redirect_val = 1'b0;
        wait_inst("d_first_wait", 30);
        chk("d_first_pc", inst_pc, 32'h0008_0100);
        repeat (20) @(negedge clk);

        // Redirect coinciding with a response, a request accept and inst_rdy.
        do_reset();
        release_reset(1'b1, 1'b1, 1'b1);
        @(negedge clk);
        req_rdy1 = 1'b0;
        @(negedge clk);
        req_rdy1 = 1'b1;
        redirect_val = 1'b1;
        redirect_pc = 32'h0008_0200;
        sb_restart(32'h0008_0200);
        #2;
        chk("e_inst_masked", {31'b0, inst_val}, 32'd0);
        chk("e_req1_accept", {31'b0, req_val1}, 32'd1);
        chk("e_resp0_arrive", {31'b0, resp_val0}, 32'd1);
        @(negedge clk);
        redirect_val = 1'b0;
        #2;
        chk("e_new_addr0", req_msg0[65:34], 32'h0008_0200);
        chk("e_new_val1", {31'b0, req_val1}, 32'd1);
        chk("e_new_addr1", req_msg1[65:34], 32'h0008_0204);
        wait_inst("e_first_wait", 20);
        chk("e_first_pc", inst_pc, 32'h0008_0200);
        repeat (10) @(negedge clk);

        // Random delays, backpressure and redirects.
        do_reset();
        min_delay = 0;
        max_delay = 4;
        release_reset(1'b1, 1'b1, 1'b1);
        start = pkt_cnt;
        for (int i = 0; i < 40000 && (pkt_cnt - start) < 1000; i++) begin
            @(negedge clk);
            req_rdy0 = ($urandom_range(0, 3) != 0);
            req_rdy1 = ($urandom_range(0, 3) != 0);
            inst_rdy = ($urandom_range(0, 3) != 0);
            if (redirect_val) begin
                redirect_val = 1'b0;
            end else if ($urandom_range(0, 39) == 0) begin
                rpc = $urandom();
                rpc = {12'h000, rpc[19:2], 2'b00};
                if ($urandom_range(0, 7) == 0) rpc = 32'hFFFF_FFF0;
                redirect_val = 1'b1;
                redirect_pc = rpc;
                sb_restart(rpc);
            end
        end
        @(negedge clk);
        redirect_val = 1'b0;
        repeat (5) @(negedge clk);
        chk("f_packets", {31'b0, (pkt_cnt - start) >= 1000}, 32'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
